dphy_lane_deser: RTL and testbench

- Multi-lane D-PHY HS deserialiser with per-lane byte alignment, running entirely in the `sys_clk` domain.
- Each lane takes DIN_W bits per clock from an arch DDR/gearbox primitive, LSB (earliest bit) first, and hunts for the HS sync byte at any bit offset.
- Once the sync byte is found, the lane locks its offset and emits aligned bytes with a valid strobe.
- Sits between the arch input primitives and the CSI-2 packet/lane-merge logic.

---
 rtl/dphy_lane_deser.sv | 163 ++++++++++++++++
 tb/tb_dphy_lane_deser.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_lane_deser.sv
// Multi-lane D-PHY HS deserialiser: each lane hunts for the HS sync byte at any
// bit offset, locks that offset and then emits aligned bytes with a valid strobe.

module dphy_lane_deser_lane #(
    parameter int          DIN_W        = 2,
    parameter logic [7:0]  SYNC_WORD    = 8'hB8,
    parameter int          HUNT_TIMEOUT = 64
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             hs_en,
    input  logic [DIN_W-1:0] din,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             locked,
    output logic             locked_nxt,
    output logic             sync_err
);
    localparam int TW      = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
    localparam int TO_LAST = (HUNT_TIMEOUT > 0) ? HUNT_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [15:0]     hist, hist_nxt;
    logic [2:0]      off, off_nxt;
    logic [2:0]      bitcnt, bitcnt_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [3:0]      bit_sum;
    logic [7:0]      byte_sel;
    logic [2:0]      match_off;
    logic            match;
    logic            emit;
    logic            err_nxt;

    // Newest bits enter at the MSB end; bit 15 of hist_nxt is the latest bit.
    assign hist_nxt = 16'({din, hist} >> DIN_W);
    assign bit_sum  = {1'b0, bitcnt} + 4'(DIN_W);
    assign byte_sel = hist_nxt[4'd15 - {1'b0, off} -: 8];

    // Scan downward so the smallest matching offset wins.
    always_comb begin
        match     = 1'b0;
        match_off = '0;
        for (int j = DIN_W - 1; j >= 0; j--) begin
            if (hist_nxt[15-j -: 8] == SYNC_WORD) begin
                match     = 1'b1;
                match_off = 3'(j);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        off_nxt    = off;
        bitcnt_nxt = bitcnt;
        tcnt_nxt   = tcnt;
        err_nxt    = 1'b0;
        emit       = 1'b0;
        if (!hs_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = HUNT;
                    tcnt_nxt  = '0;
                end
                HUNT: begin
                    if (match) begin
                        state_nxt  = LOCKED;
                        off_nxt    = match_off;
                        bitcnt_nxt = '0;
                    end else if (HUNT_TIMEOUT != 0 && tcnt == TW'(TO_LAST)) begin
                        err_nxt  = 1'b1;
                        tcnt_nxt = '0;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                LOCKED: begin
                    bitcnt_nxt = bit_sum[2:0];
                    emit       = bit_sum[3];
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            hist       <= '0;
            off        <= '0;
            bitcnt     <= '0;
            tcnt       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hist       <= hist_nxt;
            off        <= off_nxt;
            bitcnt     <= bitcnt_nxt;
            tcnt       <= tcnt_nxt;
            dout_valid <= emit;
            sync_err   <= err_nxt;
            if (emit) dout <= byte_sel;
        end
    end

    assign locked     = (state == LOCKED);
    assign locked_nxt = (state_nxt == LOCKED);
endmodule

module dphy_lane_deser #(
    parameter int          LANES        = 2,
    parameter int          DIN_W        = 2,
    parameter logic [7:0]  SYNC_WORD    = 8'hB8,
    parameter int          HUNT_TIMEOUT = 64
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       hs_en,
    input  logic [LANES*DIN_W-1:0] din,
    output logic [LANES*8-1:0]     dout,
    output logic [LANES-1:0]       dout_valid,
    output logic [LANES-1:0]       locked,
    output logic                   all_locked,
    output logic [LANES-1:0]       sync_err
);
    if (!(DIN_W == 1 || DIN_W == 2 || DIN_W == 4 || DIN_W == 8)) begin : g_bad_din_w
        $error("DIN_W must be 1, 2, 4 or 8");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("LANES must be 1..4");
    end

    logic [LANES-1:0] lock_nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dphy_lane_deser_lane #(
            .DIN_W        (DIN_W),
            .SYNC_WORD    (SYNC_WORD),
            .HUNT_TIMEOUT (HUNT_TIMEOUT)
        ) u_lane (
            .sys_clk    (sys_clk),
            .reset      (reset),
            .hs_en      (hs_en[i]),
            .din        (din[i*DIN_W +: DIN_W]),
            .dout       (dout[i*8 +: 8]),
            .dout_valid (dout_valid[i]),
            .locked     (locked[i]),
            .locked_nxt (lock_nxt[i]),
            .sync_err   (sync_err[i])
        );
    end

    // Built from next-state so it moves on the same edge as the per-lane locked bits.
    always_ff @(posedge sys_clk) begin
        if (reset) all_locked <= 1'b0;
        else       all_locked <= &lock_nxt;
    end
endmodule

// File: tb/tb_dphy_lane_deser.sv
// Randomised and directed bench for dphy_lane_deser against a bit-position
// based reference model (sync located by absolute bit index in the stream).

module tb_dphy_lane_deser;
    localparam int         LANES = 2;
    localparam int         DIN_W = 2;
    localparam int         TO    = 64;
    localparam logic [7:0] SYNC  = 8'hB8;
    localparam int         HMAX  = 32768;
    localparam int         SMAX  = 4096;

    logic                   sys_clk = 1'b0;
    logic                   reset;
    logic [LANES-1:0]       hs_en;
    logic [LANES*DIN_W-1:0] din;
    logic [LANES*8-1:0]     dout;
    logic [LANES-1:0]       dout_valid;
    logic [LANES-1:0]       locked;
    logic                   all_locked;
    logic [LANES-1:0]       sync_err;

    always #5 sys_clk = ~sys_clk;

    dphy_lane_deser #(.LANES(LANES), .DIN_W(DIN_W), .SYNC_WORD(SYNC), .HUNT_TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .reset(reset), .hs_en(hs_en), .din(din), .dout(dout),
        .dout_valid(dout_valid), .locked(locked), .all_locked(all_locked), .sync_err(sync_err)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Received bit history per lane, indexed by absolute arrival position.
    logic hb [LANES][HMAX];
    int   hlen [LANES];
    // Pending stimulus bits per lane.
    logic sb [LANES][SMAX];
    int   swr [LANES];
    int   srd [LANES];
    bit   fill_rand = 1'b0;

    int         mst [LANES];      // 0 idle, 1 hunting, 2 locked
    int         lock_end [LANES]; // position of the last sync bit
    int         hcnt [LANES];
    logic [7:0] m_dout [LANES];
    logic       m_dv [LANES];
    logic       m_err [LANES];

    function automatic logic [7:0] byte_at(int l, int e);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = hb[l][e-7+k];
        return b;
    endfunction

    task automatic push_bit(input int l, input logic v);
        sb[l][swr[l]] = v;
        swr[l]++;
    endtask

    task automatic push_byte(input int l, input logic [7:0] v);
        for (int k = 0; k < 8; k++) push_bit(l, v[k]);
    endtask

    task automatic model_edge(input logic [LANES*DIN_W-1:0] d);
        for (int l = 0; l < LANES; l++) begin
            if (reset) begin
                for (int k = 0; k < 16; k++) hb[l][k] = 1'b0;
                hlen[l] = 16; mst[l] = 0; m_dout[l] = 8'h00;
                m_dv[l] = 1'b0; m_err[l] = 1'b0; lock_end[l] = 0; hcnt[l] = 0;
                continue;
            end
            if (hlen[l] + DIN_W > HMAX) begin
                $display("FAIL history_overflow got=%0d exp=%0d", hlen[l], HMAX);
                $fatal(1);
            end
            for (int b = 0; b < DIN_W; b++) begin
                hb[l][hlen[l]] = d[l*DIN_W + b];
                hlen[l]++;
            end
            m_dv[l]  = 1'b0;
            m_err[l] = 1'b0;
            if (!hs_en[l]) begin
                mst[l] = 0;
            end else if (mst[l] == 0) begin
                mst[l] = 1; hcnt[l] = 0;
            end else if (mst[l] == 1) begin
                int found = -1;
                for (int j = 0; j < DIN_W; j++) begin
                    int e = hlen[l] - 1 - j;
                    if (found < 0 && byte_at(l, e) == SYNC) begin
                        found = j; lock_end[l] = e;
                    end
                end
                if (found >= 0) mst[l] = 2;
                else begin
                    hcnt[l]++;
                    if (hcnt[l] % TO == 0) m_err[l] = 1'b1;
                end
            end else begin
                for (int e = hlen[l] - DIN_W; e < hlen[l]; e++) begin
                    if (e > lock_end[l] && (e - lock_end[l]) % 8 == 0) begin
                        m_dout[l] = byte_at(l, e);
                        m_dv[l]   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [LANES*DIN_W-1:0] d;
        logic                   all_exp;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < DIN_W; b++) begin
                if (srd[l] < swr[l]) begin
                    d[l*DIN_W + b] = sb[l][srd[l]];
                    srd[l]++;
                end else begin
                    d[l*DIN_W + b] = fill_rand ? 1'($urandom) : 1'b0;
                end
            end
        end
        din = d;
        model_edge(d);
        @(posedge sys_clk);
        #1;
        all_exp = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            chk($sformatf("dout%0d", l), 32'(dout[l*8 +: 8]), 32'(m_dout[l]));
            chk($sformatf("dout_valid%0d", l), 32'(dout_valid[l]), 32'(m_dv[l]));
            chk($sformatf("locked%0d", l), 32'(locked[l]), 32'(mst[l] == 2));
            chk($sformatf("sync_err%0d", l), 32'(sync_err[l]), 32'(m_err[l]));
            if (mst[l] != 2) all_exp = 1'b0;
        end
        chk("all_locked", 32'(all_locked), 32'(all_exp));
    endtask

    int t_first, t_second, n_err, n_stb;

    initial begin
        for (int l = 0; l < LANES; l++) begin
            swr[l] = 0; srd[l] = 0; hlen[l] = 0;
        end
        reset = 1'b1; hs_en = '0; din = '0;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Aligned sync on lane 0: B8 then 5A, two bits per cycle.
        hs_en = 2'b01;
        step();
        push_byte(0, 8'hB8); push_byte(0, 8'h5A);
        repeat (4) step();
        chk("aligned_lock", 32'(locked[0]), 32'd1);
        repeat (4) step();
        chk("aligned_valid", 32'(dout_valid[0]), 32'd1);
        chk("aligned_data", 32'(dout[7:0]), 32'h5A);
        repeat (2) step();
        hs_en = 2'b00; step();

        // One prefix bit shifts the sync to offset 1.
        hs_en = 2'b01; step();
        push_bit(0, 1'b0); push_byte(0, 8'hB8); push_byte(0, 8'h3C); push_byte(0, 8'hFF);
        t_first = -1; t_second = -1; n_stb = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (dout_valid[0]) begin
                if (n_stb == 0) begin t_first = c; chk("unal_b0", 32'(dout[7:0]), 32'h3C); end
                if (n_stb == 1) begin t_second = c; chk("unal_b1", 32'(dout[7:0]), 32'hFF); end
                n_stb++;
            end
        end
        chk("unal_gap", 32'(t_second - t_first), 32'd4);
        hs_en = 2'b00; step();

        // Hunt timeout with a silent line.
        hs_en = 2'b01; step();
        n_err = 0; t_first = -1; t_second = -1;
        for (int c = 1; c <= 130; c++) begin
            step();
            if (sync_err[0]) begin
                if (n_err == 0) t_first = c;
                if (n_err == 1) t_second = c;
                n_err++;
            end
        end
        chk("timeout_cnt", 32'(n_err), 32'd2);
        chk("timeout_t0", 32'(t_first), 32'd64);
        chk("timeout_t1", 32'(t_second), 32'd128);
        hs_en = 2'b00; step();

        // Drop enable mid-byte, then relock.
        hs_en = 2'b01; step();
        push_byte(0, 8'hB8); push_bit(0, 1'b1); push_bit(0, 1'b1); push_bit(0, 1'b0); push_bit(0, 1'b1);
        repeat (6) step();
        hs_en = 2'b00; step();
        chk("drop_locked", 32'(locked[0]), 32'd0);
        hs_en = 2'b01; step();
        push_byte(0, 8'hB8); push_byte(0, 8'hA5);
        repeat (8) step();
        chk("relock_data", 32'(dout[7:0]), 32'hA5);
        repeat (2) step();
        hs_en = 2'b00; step();

        // Two lanes, lane 1 syncs three cycles later.
        hs_en = 2'b11; step();
        push_byte(0, 8'hB8); push_byte(0, 8'h11); push_byte(0, 8'h22); push_byte(0, 8'h33);
        repeat (6) push_bit(1, 1'b0);
        push_byte(1, 8'hB8); push_byte(1, 8'h44); push_byte(1, 8'h55); push_byte(1, 8'h66);
        repeat (20) step();

        // Reset while locked.
        fill_rand = 1'b1;
        repeat (3) step();
        reset = 1'b1; step();
        reset = 1'b0; hs_en = 2'b10;
        repeat (4) step();
        hs_en = 2'b00; step();

        // Random traffic with sync injection, enable toggles and rare resets.
        hs_en = 2'b11;
        for (int c = 0; c < 2500; c++) begin
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(63) == 0) hs_en[l] = ~hs_en[l];
                if (srd[l] == swr[l] && swr[l] < SMAX - 32 && $urandom_range(39) == 0) begin
                    push_byte(l, SYNC);
                    push_byte(l, 8'($urandom));
                end
            end
            reset = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
